btn_debounce_pulse: RTL and testbench

//  Front end for the 4 board push-buttons. Drives the toggle-enable inputs of the LED block.

---
 rtl/btn_debounce_pulse.sv | 126 ++++++++++++
 tb/tb_btn_debounce_pulse.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce_pulse.sv
// Push-button front end: 2-FF synchroniser, per-channel debounce FSM,
// single-cycle press pulse and one-shot long_press pulse per hold.
module btn_debounce_pulse #(
   parameter int N_BTN        = 4,
   parameter int DEBOUNCE_CYC = 20000,
   parameter int LONG_CYC     = 1000000,
   parameter bit ACTIVE_LOW   = 1'b1
) (
   input  logic             clk,
   input  logic             n_reset,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] press,
   output logic [N_BTN-1:0] long_press,
   output logic [N_BTN-1:0] level
);

   localparam int            CW       = $clog2(LONG_CYC + 1);
   localparam logic [CW-1:0] ONE      = CW'(1);
   localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYC - 1);
   localparam logic [CW-1:0] LONG_MAX = CW'(LONG_CYC);
   localparam logic [CW-1:0] LONG_PRE = CW'(LONG_CYC - 1);
   localparam logic          REL_RAW  = ACTIVE_LOW;

   typedef enum logic [1:0] {RELEASED, ARMING, PRESSED, DISARMING} state_t;

   for (genvar i = 0; i < N_BTN; i++) begin : gen_ch
      logic          sync0, sync1, p;
      state_t        state_q, state_d;
      logic [CW-1:0] cnt_q, cnt_d, hc_q, hc_d;
      logic          press_q, press_d, long_q, long_d, level_q, level_d;

      // Synchroniser resets to the released pad level so a held button
      // looks like a fresh press once reset is lifted.
      always_ff @(posedge clk or negedge n_reset) begin
         if (!n_reset) begin
            sync0 <= REL_RAW;
            sync1 <= REL_RAW;
         end else begin
            sync0 <= btn_raw[i];
            sync1 <= sync0;
         end
      end

      assign p = sync1 ^ ACTIVE_LOW;

      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         hc_d    = hc_q;
         press_d = 1'b0;
         long_d  = 1'b0;
         level_d = level_q;
         case (state_q)
            RELEASED: begin
               level_d = 1'b0;
               hc_d    = '0;
               if (p) begin
                  state_d = ARMING;
                  cnt_d   = ONE;
               end
            end
            ARMING: begin
               if (!p) begin
                  state_d = RELEASED;
                  cnt_d   = '0;
               end else if (cnt_q == DEB_LAST) begin
                  state_d = PRESSED;
                  cnt_d   = '0;
                  press_d = 1'b1;
                  level_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + ONE;
               end
            end
            PRESSED: begin
               level_d = 1'b1;
               if (!p) begin
                  state_d = DISARMING;
                  cnt_d   = ONE;
               end else if (hc_q != LONG_MAX) begin
                  // hc saturates at LONG_MAX, so long_press fires once per hold
                  hc_d   = hc_q + ONE;
                  long_d = (hc_q == LONG_PRE);
               end
            end
            DISARMING: begin
               if (p) begin
                  state_d = PRESSED;
                  cnt_d   = '0;
               end else if (cnt_q == DEB_LAST) begin
                  state_d = RELEASED;
                  cnt_d   = '0;
                  hc_d    = '0;
                  level_d = 1'b0;
               end else begin
                  cnt_d = cnt_q + ONE;
               end
            end
            default: state_d = RELEASED;
         endcase
      end

      always_ff @(posedge clk or negedge n_reset) begin
         if (!n_reset) begin
            state_q <= RELEASED;
            cnt_q   <= '0;
            hc_q    <= '0;
            press_q <= 1'b0;
            long_q  <= 1'b0;
            level_q <= 1'b0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hc_q    <= hc_d;
            press_q <= press_d;
            long_q  <= long_d;
            level_q <= level_d;
         end
      end

      assign press[i]      = press_q;
      assign long_press[i] = long_q;
      assign level[i]      = level_q;
   end

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Bench for btn_debounce_pulse with DEBOUNCE_CYC=4, LONG_CYC=12, active-low pads.
// Expected pulse events {cycle, kind, bits} are queued per scenario and matched against observed ones.
module tb_btn_debounce_pulse;

   localparam int N  = 4;
   localparam int D  = 4;
   localparam int L  = 12;
   localparam int W  = 32;

   logic         clk = 1'b0;
   logic         n_reset = 1'b0;
   logic [N-1:0] btn_raw = 4'hF;
   logic [N-1:0] press, long_press, level;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int k, k2, m, r;

   // event word: {cycle[26:0], kind (0 press, 1 long_press), bits[3:0]}
   logic [W-1:0] exp_q[$];
   logic [W-1:0] obs_q[$];
   logic [W-1:0] e, o;

   btn_debounce_pulse #(
      .N_BTN(N), .DEBOUNCE_CYC(D), .LONG_CYC(L), .ACTIVE_LOW(1'b1)
   ) dut (
      .clk(clk), .n_reset(n_reset), .btn_raw(btn_raw),
      .press(press), .long_press(long_press), .level(level)
   );

   // clock and cycle stamp: at the negedge after posedge N, cyc == N
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (press !== 4'h0) obs_q.push_back({27'(cyc), 1'b0, press});
      if (long_press !== 4'h0) obs_q.push_back({27'(cyc), 1'b1, long_press});
      if ((press | long_press) !== 4'h0) begin
         checks++;
         if ((press & long_press) !== 4'h0) begin
            errors++;
            $display("FAIL overlap cyc=%0d press=%b long_press=%b want no common bit", cyc, press, long_press);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic test_reset;
      n_reset = 1'b0;
      btn_raw = 4'hF;
      repeat (3) @(negedge clk);
      checks++;
      if ({press, long_press, level} !== 12'h0) begin
         errors++;
         $display("FAIL reset_hold got %h want 000", {press, long_press, level});
      end
      n_reset = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         checks++;
         if ({press, long_press, level} !== 12'h0) begin
            errors++;
            $display("FAIL reset_idle cyc=%0d got %h want 000", cyc, {press, long_press, level});
         end
      end
      checks++;
      if (obs_q.size() !== 0) begin
         errors++;
         $display("FAIL reset_events got %0d want 0", obs_q.size());
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic test_clean_press;
      @(negedge clk);
      k = cyc;
      btn_raw[0] = 1'b0;
      exp_q.push_back({27'(k + 6), 1'b0, 4'b0001});
      repeat (5) @(negedge clk);
      checks++;
      if (level !== 4'h0) begin
         errors++;
         $display("FAIL clean_early_level got %b want 0000", level);
      end
      @(negedge clk);
      checks++;
      if (press !== 4'b0001 || level !== 4'b0001) begin
         errors++;
         $display("FAIL clean_edge press=%b level=%b want 0001/0001", press, level);
      end
      repeat (4) @(negedge clk);
      btn_raw[0] = 1'b1;
      repeat (10) @(negedge clk);
      checks++;
      if (level !== 4'h0) begin
         errors++;
         $display("FAIL clean_release_level got %b want 0000", level);
      end
      checks++;
      if (obs_q.size() !== exp_q.size()) begin
         errors++;
         $display("FAIL clean_count got %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL clean_event got cyc=%0d kind=%0d bits=%b want cyc=%0d kind=%0d bits=%b",
                     o[31:5], o[4], o[3:0], e[31:5], e[4], e[3:0]);
         end
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_bounce;
      @(negedge clk);
      btn_raw[1] = 1'b0;
      repeat (3) @(negedge clk);
      btn_raw[1] = 1'b1;
      repeat (2) @(negedge clk);
      btn_raw[1] = 1'b0;
      repeat (3) @(negedge clk);
      btn_raw[1] = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if (level[1] !== 1'b0) begin
            errors++;
            $display("FAIL bounce_level cyc=%0d got %b want 0", cyc, level[1]);
         end
      end
      // exactly DEBOUNCE_CYC low cycles is accepted
      k2 = cyc;
      btn_raw[1] = 1'b0;
      exp_q.push_back({27'(k2 + 6), 1'b0, 4'b0010});
      repeat (4) @(negedge clk);
      btn_raw[1] = 1'b1;
      repeat (5) @(negedge clk);
      checks++;
      if (level !== 4'b0010) begin
         errors++;
         $display("FAIL exact_level_hold got %b want 0010", level);
      end
      @(negedge clk);
      checks++;
      if (level !== 4'h0) begin
         errors++;
         $display("FAIL exact_level_fall got %b want 0000", level);
      end
      repeat (4) @(negedge clk);
      checks++;
      if (obs_q.size() !== exp_q.size()) begin
         errors++;
         $display("FAIL bounce_count got %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL bounce_event got cyc=%0d kind=%0d bits=%b want cyc=%0d kind=%0d bits=%b",
                     o[31:5], o[4], o[3:0], e[31:5], e[4], e[3:0]);
         end
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_long_press;
      @(negedge clk);
      k = cyc;
      btn_raw[2] = 1'b0;
      exp_q.push_back({27'(k + 6), 1'b0, 4'b0100});
      exp_q.push_back({27'(k + 6 + L), 1'b1, 4'b0100});
      repeat (40) @(negedge clk);
      r = cyc;
      btn_raw[2] = 1'b1;
      repeat (5) @(negedge clk);
      checks++;
      if (level !== 4'b0100) begin
         errors++;
         $display("FAIL long_level_hold cyc=%0d got %b want 0100", cyc - r, level);
      end
      @(negedge clk);
      checks++;
      if (level !== 4'h0) begin
         errors++;
         $display("FAIL long_level_fall cyc=%0d got %b want 0000", cyc - r, level);
      end
      repeat (4) @(negedge clk);
      checks++;
      if (obs_q.size() !== exp_q.size()) begin
         errors++;
         $display("FAIL long_count got %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL long_event got cyc=%0d kind=%0d bits=%b want cyc=%0d kind=%0d bits=%b",
                     o[31:5], o[4], o[3:0], e[31:5], e[4], e[3:0]);
         end
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_all_channels;
      @(negedge clk);
      k = cyc;
      btn_raw = 4'h0;
      exp_q.push_back({27'(k + 6), 1'b0, 4'hF});
      repeat (8) @(negedge clk);
      btn_raw = 4'hF;
      repeat (2) @(negedge clk);
      btn_raw = 4'h0;
      repeat (4) @(negedge clk);
      checks++;
      if (level !== 4'hF) begin
         errors++;
         $display("FAIL all_level_after_bounce got %b want 1111", level);
      end
      btn_raw = 4'hF;
      repeat (10) @(negedge clk);
      checks++;
      if (level !== 4'h0) begin
         errors++;
         $display("FAIL all_level_release got %b want 0000", level);
      end
      checks++;
      if (obs_q.size() !== exp_q.size()) begin
         errors++;
         $display("FAIL all_count got %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL all_event got cyc=%0d kind=%0d bits=%b want cyc=%0d kind=%0d bits=%b",
                     o[31:5], o[4], o[3:0], e[31:5], e[4], e[3:0]);
         end
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_reset_mid_arming;
      @(negedge clk);
      k = cyc;
      btn_raw[0] = 1'b0;
      exp_q.push_back({27'(k + 6), 1'b0, 4'b0001});
      repeat (8) @(negedge clk);
      k2 = cyc;
      btn_raw[3] = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if (level !== 4'b0001) begin
         errors++;
         $display("FAIL midrst_pre_level got %b want 0001", level);
      end
      // channel 3 is now two counts into arming
      n_reset = 1'b0;
      #1;
      checks++;
      if ({press, long_press, level} !== 12'h0) begin
         errors++;
         $display("FAIL midrst_async got %h want 000", {press, long_press, level});
      end
      repeat (3) @(negedge clk);
      m = cyc;
      n_reset = 1'b1;
      exp_q.push_back({27'(m + 6), 1'b0, 4'b1001});
      repeat (5) @(negedge clk);
      checks++;
      if (press !== 4'h0) begin
         errors++;
         $display("FAIL midrst_early_press got %b want 0000", press);
      end
      @(negedge clk);
      checks++;
      if (press !== 4'b1001) begin
         errors++;
         $display("FAIL midrst_press got %b want 1001", press);
      end
      repeat (2) @(negedge clk);
      btn_raw = 4'hF;
      repeat (10) @(negedge clk);
      checks++;
      if (level !== 4'h0) begin
         errors++;
         $display("FAIL midrst_release got %b want 0000", level);
      end
      checks++;
      if (obs_q.size() !== exp_q.size()) begin
         errors++;
         $display("FAIL midrst_count got %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL midrst_event got cyc=%0d kind=%0d bits=%b want cyc=%0d kind=%0d bits=%b",
                     o[31:5], o[4], o[3:0], e[31:5], e[4], e[3:0]);
         end
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_long_press();
      test_all_channels();
      test_reset_mid_arming();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
